// File: rtl/cr_lz77_comp_pkg.sv
// Shared LZ77 compressor types: PMU event pulse bundle and the counter index map
// used by everything that consumes it.
package cr_lz77_comp_pkg;

  localparam int PMU_N_EV  = 25;
  localparam int PMU_CNT_W = 32;

  // Counter index for each PMU event; this order is the read-port address map.
  typedef enum logic [4:0] {
    PMU_ONE_LIT     = 5'd0,
    PMU_TWO_LIT     = 5'd1,
    PMU_THREE_LIT   = 5'd2,
    PMU_FOUR_LIT    = 5'd3,
    PMU_PTR         = 5'd4,
    PMU_MTF         = 5'd5,
    PMU_RUN_3       = 5'd6,
    PMU_RUN_4       = 5'd7,
    PMU_RUN_5       = 5'd8,
    PMU_RUN_6       = 5'd9,
    PMU_RUN_7       = 5'd10,
    PMU_RUN_8       = 5'd11,
    PMU_RUN_9       = 5'd12,
    PMU_RUN_10      = 5'd13,
    PMU_RUN_11_31   = 5'd14,
    PMU_RUN_32_63   = 5'd15,
    PMU_RUN_64_127  = 5'd16,
    PMU_RUN_128_255 = 5'd17,
    PMU_RUN_256_NUP = 5'd18,
    PMU_MTF_0       = 5'd19,
    PMU_MTF_1       = 5'd20,
    PMU_MTF_2       = 5'd21,
    PMU_MTF_3       = 5'd22,
    PMU_BYPASS      = 5'd23,
    PMU_EOF         = 5'd24
  } lz77_pmu_ev_idx_e;

  // Field order is the packer's wire layout and deliberately unrelated to the index map.
  typedef struct packed {
    logic eof_ev;
    logic bypass_ev;
    logic ptr_ev;
    logic mtf_ev;
    logic one_lit_ev;
    logic two_lit_ev;
    logic three_lit_ev;
    logic four_lit_ev;
    logic run_3_ev;
    logic run_4_ev;
    logic run_5_ev;
    logic run_6_ev;
    logic run_7_ev;
    logic run_8_ev;
    logic run_9_ev;
    logic run_10_ev;
    logic run_11_31_ev;
    logic run_32_63_ev;
    logic run_64_127_ev;
    logic run_128_255_ev;
    logic run_256_nup_ev;
    logic mtf_0_ev;
    logic mtf_1_ev;
    logic mtf_2_ev;
    logic mtf_3_ev;
  } lob_events_t;

endpackage

// File: rtl/cr_lz77_comp_pmu_sat_cnt.sv
// One saturating live event counter; exposes its next value so the snapshot
// captures events that coincide with the trigger.
module cr_lz77_comp_pmu_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             ld_zero,
  input  logic             clr,
  output logic [CNT_W-1:0] nxt
);

  logic [CNT_W-1:0] cnt;

  assign nxt = (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || ld_zero) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/cr_lz77_comp_pmu_cnt.sv
// PMU event accumulator: live counters per event, frame-boundary snapshot into a
// shadow bank, and a pipelined one-cycle-latency read port over the shadow bank.
module cr_lz77_comp_pmu_cnt
  import cr_lz77_comp_pkg::*;
#(
  parameter int CNT_W = PMU_CNT_W,
  parameter int N_EV  = PMU_N_EV,
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  lob_events_t      lob_events,
  input  logic             cnt_clr,
  input  logic             snap_req,
  input  logic             rd_req,
  input  logic [4:0]       rd_addr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_err,
  output logic             snap_vld,
  output logic [SEQ_W-1:0] snap_seq
);

  logic [N_EV-1:0]  ev;
  logic             snap;
  logic [CNT_W-1:0] live_nxt [N_EV];
  logic [CNT_W-1:0] shadow   [N_EV];

  // Counter slots are chosen by enum name so a struct reorder cannot remap them.
  // NOTE: the default assignment first keeps this block purely combinational;
  // any path leaving a bit unassigned would infer a latch.
  always_comb begin
    ev                  = '0;
    ev[PMU_ONE_LIT]     = lob_events.one_lit_ev;
    ev[PMU_TWO_LIT]     = lob_events.two_lit_ev;
    ev[PMU_THREE_LIT]   = lob_events.three_lit_ev;
    ev[PMU_FOUR_LIT]    = lob_events.four_lit_ev;
    ev[PMU_PTR]         = lob_events.ptr_ev;
    ev[PMU_MTF]         = lob_events.mtf_ev;
    ev[PMU_RUN_3]       = lob_events.run_3_ev;
    ev[PMU_RUN_4]       = lob_events.run_4_ev;
    ev[PMU_RUN_5]       = lob_events.run_5_ev;
    ev[PMU_RUN_6]       = lob_events.run_6_ev;
    ev[PMU_RUN_7]       = lob_events.run_7_ev;
    ev[PMU_RUN_8]       = lob_events.run_8_ev;
    ev[PMU_RUN_9]       = lob_events.run_9_ev;
    ev[PMU_RUN_10]      = lob_events.run_10_ev;
    ev[PMU_RUN_11_31]   = lob_events.run_11_31_ev;
    ev[PMU_RUN_32_63]   = lob_events.run_32_63_ev;
    ev[PMU_RUN_64_127]  = lob_events.run_64_127_ev;
    ev[PMU_RUN_128_255] = lob_events.run_128_255_ev;
    ev[PMU_RUN_256_NUP] = lob_events.run_256_nup_ev;
    ev[PMU_MTF_0]       = lob_events.mtf_0_ev;
    ev[PMU_MTF_1]       = lob_events.mtf_1_ev;
    ev[PMU_MTF_2]       = lob_events.mtf_2_ev;
    ev[PMU_MTF_3]       = lob_events.mtf_3_ev;
    ev[PMU_BYPASS]      = lob_events.bypass_ev;
    ev[PMU_EOF]         = lob_events.eof_ev;
  end

  assign snap = lob_events.eof_ev | snap_req;

  for (genvar i = 0; i < N_EV; i++) begin : g_cnt
    cr_lz77_comp_pmu_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (ev[i]),
      .ld_zero (snap),
      .clr     (cnt_clr),
      .nxt     (live_nxt[i])
    );
  end

  // NOTE: the shadow bank is a flop array, not a RAM; it is reset because a
  // read straight after reset must return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '{default: '0};
    end else if (cnt_clr) begin
      shadow <= '{default: '0};
    end else if (snap) begin
      shadow <= live_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_vld <= 1'b0;
      snap_seq <= '0;
    end else if (cnt_clr) begin
      snap_vld <= 1'b0;
      snap_seq <= '0;
    end else begin
      snap_vld <= snap;
      if (snap) snap_seq <= snap_seq + SEQ_W'(1);
    end
  end

  // Reads sample the pre-edge shadow, so a read coincident with a snapshot
  // returns the closing-window-minus-one value; rd_data holds between acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      rd_err <= 1'b0;
      if (rd_req) begin
        if (int'(rd_addr) < N_EV) begin
          rd_data <= shadow[rd_addr];
        end else begin
          rd_data <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_lz77_comp_pmu_cnt.sv
// Self-checking bench: directed scenarios plus random traffic against an
// array-based reference model; a 4-bit-counter instance covers saturation.
module tb_cr_lz77_comp_pmu_cnt;
  import cr_lz77_comp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  lob_events_t lob_events;
  logic        cnt_clr = 1'b0, snap_req = 1'b0, rd_req = 1'b0;
  logic [4:0]  rd_addr = '0;

  logic        rd_ack, rd_err, snap_vld;
  logic [31:0] rd_data;
  logic [7:0]  snap_seq;
  logic        rd_ack4, rd_err4, snap_vld4;
  logic [3:0]  rd_data4;
  logic [7:0]  snap_seq4;

  logic [24:0] ev_vec = '0;

  always #5 clk = ~clk;

  cr_lz77_comp_pmu_cnt dut (
    .clk(clk), .rst_n(rst_n), .lob_events(lob_events), .cnt_clr(cnt_clr),
    .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_err(rd_err), .snap_vld(snap_vld), .snap_seq(snap_seq)
  );

  cr_lz77_comp_pmu_cnt #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .lob_events(lob_events), .cnt_clr(cnt_clr),
    .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack4),
    .rd_data(rd_data4), .rd_err(rd_err4), .snap_vld(snap_vld4), .snap_seq(snap_seq4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Event vector bit k is counter k of the address map, written out by name.
  function automatic lob_events_t to_struct(input logic [24:0] v);
    lob_events_t s;
    s = '0;
    s.one_lit_ev = v[0];      s.two_lit_ev = v[1];      s.three_lit_ev = v[2];
    s.four_lit_ev = v[3];     s.ptr_ev = v[4];          s.mtf_ev = v[5];
    s.run_3_ev = v[6];        s.run_4_ev = v[7];        s.run_5_ev = v[8];
    s.run_6_ev = v[9];        s.run_7_ev = v[10];       s.run_8_ev = v[11];
    s.run_9_ev = v[12];       s.run_10_ev = v[13];      s.run_11_31_ev = v[14];
    s.run_32_63_ev = v[15];   s.run_64_127_ev = v[16];  s.run_128_255_ev = v[17];
    s.run_256_nup_ev = v[18]; s.mtf_0_ev = v[19];       s.mtf_1_ev = v[20];
    s.mtf_2_ev = v[21];       s.mtf_3_ev = v[22];       s.bypass_ev = v[23];
    s.eof_ev = v[24];
    return s;
  endfunction

  // Reference model: plain integer arrays, two counter widths.
  longint m_live32 [25], m_live4 [25], m_shd32 [25], m_shd4 [25];
  longint m_data32, m_data4;
  int     m_seq;
  bit     m_vld, m_ack, m_err;

  function automatic void model_reset();
    for (int i = 0; i < 25; i++) begin
      m_live32[i] = 0; m_live4[i] = 0; m_shd32[i] = 0; m_shd4[i] = 0;
    end
    m_data32 = 0; m_data4 = 0; m_seq = 0; m_vld = 0; m_ack = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    bit trig;
    m_ack = rd_req;
    m_err = 0;
    if (rd_req) begin
      if (rd_addr < 25) begin
        m_data32 = m_shd32[rd_addr]; m_data4 = m_shd4[rd_addr];
      end else begin
        m_data32 = 0; m_data4 = 0; m_err = 1;
      end
    end
    if (cnt_clr) begin
      for (int i = 0; i < 25; i++) begin
        m_live32[i] = 0; m_live4[i] = 0; m_shd32[i] = 0; m_shd4[i] = 0;
      end
      m_seq = 0; m_vld = 0;
    end else begin
      trig = ev_vec[24] | snap_req;
      for (int i = 0; i < 25; i++) begin
        if (ev_vec[i]) begin
          if (m_live32[i] < 64'd4294967295) m_live32[i]++;
          if (m_live4[i] < 15) m_live4[i]++;
        end
        if (trig) begin
          m_shd32[i] = m_live32[i]; m_shd4[i] = m_live4[i];
          m_live32[i] = 0; m_live4[i] = 0;
        end
      end
      m_vld = trig;
      if (trig) m_seq = (m_seq + 1) % 256;
    end
  endfunction

  task automatic tick();
    lob_events = to_struct(ev_vec);
    @(posedge clk);
    model_step();
    #1;
    check("snap_vld", snap_vld, m_vld);
    check("snap_seq", snap_seq, m_seq);
    check("snap_seq4", snap_seq4, m_seq);
    check("rd_ack", rd_ack, m_ack);
    check("rd_data32", rd_data, m_data32);
    check("rd_data4", rd_data4, m_data4);
    if (m_ack) begin
      check("rd_err", rd_err, m_err);
      check("rd_err4", rd_err4, m_err);
    end
    ev_vec = '0; snap_req = 1'b0; cnt_clr = 1'b0; rd_req = 1'b0;
    lob_events = to_struct(ev_vec);
  endtask

  task automatic do_read(input int addr);
    rd_req = 1'b1;
    rd_addr = 5'(addr);
    tick();
  endtask

  task automatic pulse(input int idx, input int times);
    for (int k = 0; k < times; k++) begin
      ev_vec[idx] = 1'b1;
      tick();
    end
  endtask

  initial begin
    lob_events = to_struct('0);
    model_reset();
    #1;
    check("rst_snap_vld", snap_vld, 0);
    check("rst_snap_seq", snap_seq, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_err", rd_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 25; a++) do_read(a);
    do_read(25);
    do_read(31);

    pulse(4, 7);
    ev_vec[24] = 1'b1;
    tick();
    check("eof_snap_vld", snap_vld, 1);
    check("eof_snap_seq", snap_seq, 1);
    do_read(4);  check("ptr_count", rd_data, 7);
    do_read(24); check("eof_count", rd_data, 1);
    do_read(5);  check("mtf_count", rd_data, 0);
    ev_vec[24] = 1'b1; tick();
    do_read(4);  check("ptr_after_empty", rd_data, 0);

    ev_vec[21] = 1'b1; ev_vec[24] = 1'b1; tick();
    do_read(21); check("mtf2_coincident", rd_data, 1);
    ev_vec[24] = 1'b1; tick();
    do_read(21); check("mtf2_cleared", rd_data, 0);

    pulse(0, 20);
    snap_req = 1'b1; tick();
    do_read(0);
    check("one_lit_32", rd_data, 20);
    check("one_lit_sat4", rd_data4, 15);

    pulse(6, 3);
    ev_vec[24] = 1'b1; tick();
    do_read(6);  check("run3_before_clr", rd_data, 3);
    cnt_clr = 1'b1; ev_vec[24] = 1'b1; ev_vec[6] = 1'b1; tick();
    check("clr_snap_vld", snap_vld, 0);
    check("clr_snap_seq", snap_seq, 0);
    do_read(6);  check("run3_after_clr", rd_data, 0);

    pulse(4, 5);
    ev_vec[24] = 1'b1; tick();
    pulse(4, 2);
    do_read(4);
    rd_req = 1'b1; rd_addr = 5'd4; ev_vec[24] = 1'b1; tick();
    check("b2b_mid_old", rd_data, 5);
    do_read(4);
    check("b2b_new", rd_data, 2);

    for (int s = 0; s < 256; s++) begin
      snap_req = 1'b1;
      tick();
    end
    check("seq_full_lap", snap_seq, m_seq);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 24; i++) ev_vec[i] = ($urandom_range(3) == 0);
      ev_vec[24] = ($urandom_range(15) == 0);
      snap_req   = ($urandom_range(31) == 0);
      cnt_clr    = ($urandom_range(127) == 0);
      rd_req     = ($urandom_range(1) == 1);
      rd_addr    = 5'($urandom_range(31));
      tick();
    end

    ev_vec[24] = 1'b1; pulse(3, 1);
    rd_req = 1'b1; rd_addr = 5'd24; ev_vec[24] = 1'b1; tick();
    rd_req = 1'b1; rd_addr = 5'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_ack", rd_ack, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_rd_err", rd_err, 0);
    check("arst_snap_vld", snap_vld, 0);
    check("arst_snap_seq", snap_seq, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    rst_n = 1'b1;
    tick();
    check("arst_no_late_ack", rd_ack, 0);
    do_read(3);  check("arst_shadow_zero", rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
